// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I decode/issue register in front of the alu (optional feature: ALU_ISSUE_ILLEGAL_EN)
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [2:0]      o_opsel,
  output logic            o_sub,
  output logic            o_unsigned,
  output logic            o_arith,
  output logic [XLEN-1:0] o_op1,
  output logic [XLEN-1:0] o_op2,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic            o_illegal,
`endif
  output logic [15:0]     o_issued
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_rd;

  assign opcode    = i_instr[6:0];
  assign f3        = i_instr[14:12];
  assign f7b5      = i_instr[30];
  assign unused_rd = ^i_instr[11:7];

  logic            dec_legal;
  logic [2:0]      dec_opsel;
  logic            dec_sub, dec_uns, dec_arith;
  logic [XLEN-1:0] dec_op1, dec_op2;

  logic            valid_q, valid_d;
  logic [2:0]      opsel_q, opsel_d;
  logic            sub_q, sub_d, uns_q, uns_d, arith_q, arith_d;
  logic [XLEN-1:0] op1_q, op1_d, op2_q, op2_d;
  logic            illegal_q, illegal_d;
  logic [15:0]     issued_q, issued_d;

  logic up_xfer, dn_xfer;

  assign o_ready = !valid_q | i_ready;
  assign up_xfer = i_valid & o_ready;
  assign dn_xfer = valid_q & i_ready;

  // Decode the incoming instruction into alu controls; unknown opcodes decode to all-zero fields
  always_comb begin
    dec_legal = 1'b1;
    dec_opsel = 3'b000;
    dec_sub   = 1'b0;
    dec_uns   = 1'b0;
    dec_arith = 1'b0;
    dec_op1   = '0;
    dec_op2   = '0;
    case (opcode)
      7'b0110011: begin
        dec_opsel = f3;
        dec_sub   = f7b5 & (f3 == 3'b000);
        dec_arith = f7b5 & (f3 == 3'b101);
        dec_uns   = (f3 == 3'b011);
        dec_op1   = i_rs1;
        dec_op2   = i_rs2;
      end
      7'b0010011: begin
        dec_opsel = f3;
        dec_arith = f7b5 & (f3 == 3'b101);
        dec_uns   = (f3 == 3'b011);
        dec_op1   = i_rs1;
        dec_op2   = {{20{i_instr[31]}}, i_instr[31:20]};
      end
      7'b0110111: begin
        dec_op2 = {i_instr[31:12], 12'b0};
      end
      7'b0010111: begin
        dec_op1 = i_pc;
        dec_op2 = {i_instr[31:12], 12'b0};
      end
      7'b1100011: begin
        dec_opsel = 3'b010;
        dec_sub   = 1'b1;
        dec_uns   = f3[1];
        dec_op1   = i_rs1;
        dec_op2   = i_rs2;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Next-state for the single-entry issue register; flush wins over fill, fill wins over drain
  always_comb begin
    valid_d   = valid_q;
    opsel_d   = opsel_q;
    sub_d     = sub_q;
    uns_d     = uns_q;
    arith_d   = arith_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    illegal_d = illegal_q;
    issued_d  = (dn_xfer && !i_flush) ? issued_q + 16'd1 : issued_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (up_xfer) begin
`ifdef ALU_ISSUE_ILLEGAL_EN
      valid_d   = 1'b1;
      illegal_d = !dec_legal;
`else
      valid_d   = dec_legal;
      illegal_d = 1'b0;
`endif
      if (valid_d) begin
        opsel_d = dec_opsel;
        sub_d   = dec_sub;
        uns_d   = dec_uns;
        arith_d = dec_arith;
        op1_d   = dec_op1;
        op2_d   = dec_op2;
      end
    end else if (dn_xfer) begin
      valid_d = 1'b0;
    end
  end

  // Issue register; asynchronous reset discards any held entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      opsel_q   <= 3'b000;
      sub_q     <= 1'b0;
      uns_q     <= 1'b0;
      arith_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      illegal_q <= 1'b0;
      issued_q  <= 16'd0;
    end else begin
      valid_q   <= valid_d;
      opsel_q   <= opsel_d;
      sub_q     <= sub_d;
      uns_q     <= uns_d;
      arith_q   <= arith_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      illegal_q <= illegal_d;
      issued_q  <= issued_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_opsel    = opsel_q;
  assign o_sub      = sub_q;
  assign o_unsigned = uns_q;
  assign o_arith    = arith_q;
  assign o_op1      = op1_q;
  assign o_op2      = op2_q;
  assign o_issued   = issued_q;
`ifdef ALU_ISSUE_ILLEGAL_EN
  assign o_illegal  = illegal_q;
`else
  logic unused_illegal;
  assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage (optional feature: ALU_ISSUE_ILLEGAL_EN)
module tb_alu_issue_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_flush, i_valid, i_ready;
  logic [31:0] i_instr, i_pc, i_rs1, i_rs2;
  logic        o_ready, o_valid, o_sub, o_unsigned, o_arith;
  logic [2:0]  o_opsel;
  logic [31:0] o_op1, o_op2;
  logic [15:0] o_issued;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic        o_illegal;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int exp_iss = 0;

  always #5 i_clk = ~i_clk;

  alu_issue_stage dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_instr    (i_instr),
    .i_pc       (i_pc),
    .i_rs1      (i_rs1),
    .i_rs2      (i_rs2),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_opsel    (o_opsel),
    .o_sub      (o_sub),
    .o_unsigned (o_unsigned),
    .o_arith    (o_arith),
    .o_op1      (o_op1),
    .o_op2      (o_op2),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .o_illegal  (o_illegal),
`endif
    .o_issued   (o_issued)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic r, input logic [31:0] ins,
                       input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    i_valid = v; i_ready = r; i_instr = ins; i_pc = pc; i_rs1 = a; i_rs2 = b;
  endtask

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #22;
    check("rst_valid",  {31'b0, o_valid}, 32'd0);
    check("rst_issued", {16'b0, o_issued}, 32'd0);
    check("rst_ready",  {31'b0, o_ready}, 32'd1);
    check("rst_op2",    o_op2, 32'd0);
    i_rst_n = 1'b1;
    step();

    // sub x3,x1,x2
    drive(1'b1, 1'b1, 32'h402081B3, 32'h100, 32'd50, 32'd20);
    step();
    check("sub_valid", {31'b0, o_valid}, 32'd1);
    check("sub_opsel", {29'b0, o_opsel}, 32'd0);
    check("sub_sub",   {31'b0, o_sub}, 32'd1);
    check("sub_op1",   o_op1, 32'd50);
    check("sub_op2",   o_op2, 32'd20);
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("sub_illegal", {31'b0, o_illegal}, 32'd0);
`endif

    // srai x3,x1,1 ; the sub drains on this edge
    drive(1'b1, 1'b1, 32'h4010D193, 32'h104, 32'hFFFFFFFC, 32'd9);
    step(); exp_iss++;
    check("srai_opsel", {29'b0, o_opsel}, 32'd5);
    check("srai_arith", {31'b0, o_arith}, 32'd1);
    check("srai_sub",   {31'b0, o_sub}, 32'd0);
    check("srai_shamt", {27'b0, o_op2[4:0]}, 32'd1);
    check("srai_op1",   o_op1, 32'hFFFFFFFC);
    check("srai_iss",   {16'b0, o_issued}, exp_iss);

    // addi x3,x1,-1
    drive(1'b1, 1'b1, 32'hFFF08193, 32'h108, 32'd7, 32'd9);
    step(); exp_iss++;
    check("addi_opsel", {29'b0, o_opsel}, 32'd0);
    check("addi_sub",   {31'b0, o_sub}, 32'd0);
    check("addi_op2",   o_op2, 32'hFFFFFFFF);
    check("addi_op1",   o_op1, 32'd7);

    // bltu held under backpressure
    drive(1'b1, 1'b1, 32'h0020E063, 32'h10C, 32'hAAAA0001, 32'h5555000F);
    step(); exp_iss++;
    drive(1'b1, 1'b0, 32'h123451B7, 32'h110, 32'h1, 32'h2);
    #1;
    check("bp_ready", {31'b0, o_ready}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_valid", {31'b0, o_valid}, 32'd1);
      check("bp_op1",   o_op1, 32'hAAAA0001);
      check("bp_op2",   o_op2, 32'h5555000F);
    end
    check("bltu_opsel", {29'b0, o_opsel}, 32'd2);
    check("bltu_sub",   {31'b0, o_sub}, 32'd1);
    check("bltu_uns",   {31'b0, o_unsigned}, 32'd1);
    check("bp_iss",     {16'b0, o_issued}, exp_iss);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); exp_iss++;
    check("drain_valid", {31'b0, o_valid}, 32'd0);
    check("drain_iss",   {16'b0, o_issued}, exp_iss);

    // lui back-to-back, four ops
    drive(1'b1, 1'b1, 32'h123451B7, 32'h200, 32'h33, 32'h44);
    for (int k = 0; k < 4; k++) begin
      step();
      if (k > 0) exp_iss++;
      check("lui_valid", {31'b0, o_valid}, 32'd1);
      check("lui_op2",   o_op2, 32'h12345000);
      check("lui_op1",   o_op1, 32'd0);
    end
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); exp_iss++;
    check("lui_iss", {16'b0, o_issued}, 32'd8);

    // auipc
    drive(1'b1, 1'b1, 32'h00001197, 32'h00000400, 32'h1, 32'h2);
    step();
    check("auipc_op1", o_op1, 32'h00000400);
    check("auipc_op2", o_op2, 32'h00001000);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); exp_iss++;

    // unrecognised opcode
    drive(1'b1, 1'b1, 32'h0000007F, 32'h300, 32'h77, 32'h88);
    step();
`ifdef ALU_ISSUE_ILLEGAL_EN
    check("ill_valid",   {31'b0, o_valid}, 32'd1);
    check("ill_flag",    {31'b0, o_illegal}, 32'd1);
    check("ill_op1",     o_op1, 32'd0);
    check("ill_op2",     o_op2, 32'd0);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); exp_iss++;
`else
    check("ill_valid",   {31'b0, o_valid}, 32'd0);
    drive(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
`endif
    check("ill_iss", {16'b0, o_issued}, exp_iss);

    // flush a held entry, blocking a same-cycle fill
    drive(1'b1, 1'b0, 32'h123451B7, 32'h400, 32'h0, 32'h0);
    step();
    check("fl_held", {31'b0, o_valid}, 32'd1);
    i_flush = 1'b1;
    drive(1'b1, 1'b1, 32'h402081B3, 32'h404, 32'd1, 32'd2);
    step();
    i_flush = 1'b0;
    check("fl_valid", {31'b0, o_valid}, 32'd0);
    check("fl_iss",   {16'b0, o_issued}, exp_iss);

    // asynchronous reset while an entry is held
    drive(1'b1, 1'b0, 32'h402081B3, 32'h408, 32'd3, 32'd4);
    step();
    check("ar_held", {31'b0, o_valid}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("ar_valid", {31'b0, o_valid}, 32'd0);
    check("ar_iss",   {16'b0, o_issued}, 32'd0);
    i_rst_n = 1'b1;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
